writeback_stage: RTL

- Final pipeline stage; consumes instructions leaving execute-2 (pc, opcode, destination register, scalar result, vector result).
- Commits scalar results to the scalar register file in one cycle.
- Commits vector results lane-by-lane through a single-write-port vector register file, back-pressuring execute-2 while lanes drain.
- Tracks retirement count and halt.

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/vlane_sequencer.sv | 85 ++++++++
 rtl/writeback_stage.sv | 81 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, vector geometry and the opcode classifier
// used by decode, execute and writeback.
package cpu_pkg;

  localparam int VLEN   = 4;
  localparam int LANE_W = 2;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_MOVL = 4'h4;
  localparam logic [3:0] OP_MOVH = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;
  localparam logic [3:0] OP_ST7  = 4'h7;
  localparam logic [3:0] OP_VADD = 4'h8;
  localparam logic [3:0] OP_VSUB = 4'h9;
  localparam logic [3:0] OP_VMUL = 4'hA;
  localparam logic [3:0] OP_VDIV = 4'hB;
  localparam logic [3:0] OP_STC  = 4'hC;
  localparam logic [3:0] OP_STD  = 4'hD;
  localparam logic [3:0] OP_VLD  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SCALAR,
    CLS_VECTOR,
    CLS_HALT
  } op_class_e;

  typedef enum logic {
    ST_IDLE,
    ST_VWRITE
  } vseq_state_e;

  function automatic op_class_e op_class(input logic [3:0] opcode);
    op_class_e cls;
    case (opcode)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOVL, OP_MOVH: cls = CLS_SCALAR;
      OP_VADD, OP_VSUB, OP_VMUL, OP_VDIV, OP_VLD:       cls = CLS_VECTOR;
      OP_HALT:                                          cls = CLS_HALT;
      default:                                          cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/vlane_sequencer.sv
// Captures a vector result and drains it one lane per cycle into the
// single-write-port vector register file; a new capture may land on the last lane.
module vlane_sequencer #(
  parameter int VLEN   = cpu_pkg::VLEN,
  parameter int LANE_W = cpu_pkg::LANE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               start_rt,
  input  logic [16*VLEN-1:0]       start_vdata,
  output logic                     vrf_we,
  output logic [3:0]               vrf_waddr,
  output logic [LANE_W-1:0]        vrf_lane,
  output logic [15:0]              vrf_wdata,
  output logic                     busy,
  output logic                     last_lane,
  output cpu_pkg::vseq_state_e     state_dbg
);
  import cpu_pkg::*;

  localparam logic [LANE_W-1:0] LAST = LANE_W'(VLEN - 1);

  vseq_state_e         state, state_n;
  logic [LANE_W-1:0]   lane, lane_n;
  logic                capture;
  logic [16*VLEN-1:0]  vec_q;
  logic [3:0]          rt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      lane  <= '0;
      vec_q <= '0;
      rt_q  <= '0;
    end else begin
      state <= state_n;
      lane  <= lane_n;
      if (capture) begin
        vec_q <= start_vdata;
        rt_q  <= start_rt;
      end
    end
  end

  // start is only raised by the parent when it is legal: in IDLE or on the last lane.
  always_comb begin
    state_n = state;
    lane_n  = lane;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_VWRITE;
          lane_n  = '0;
          capture = 1'b1;
        end
      end
      ST_VWRITE: begin
        if (lane != LAST) begin
          lane_n = lane + 1'b1;
        end else if (start) begin
          lane_n  = '0;
          capture = 1'b1;
        end else begin
          state_n = ST_IDLE;
          lane_n  = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        lane_n  = '0;
      end
    endcase
  end

  assign vrf_we    = (state == ST_VWRITE);
  assign busy      = (state == ST_VWRITE);
  assign vrf_waddr = rt_q;
  assign vrf_lane  = lane;
  assign vrf_wdata = vec_q[{lane, 4'b0000} +: 16];
  assign last_lane = (state == ST_VWRITE) && (lane == LAST);
  assign state_dbg = state;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: one-cycle scalar commit, lane-serial vector commit,
// retirement counting and sticky halt.
module writeback_stage #(
  parameter int VLEN   = cpu_pkg::VLEN,
  parameter int LANE_W = cpu_pkg::LANE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_pc,
  input  logic [3:0]          in_opcode,
  input  logic [3:0]          in_rt,
  input  logic [15:0]         in_result,
  input  logic [16*VLEN-1:0]  in_vresult,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic [15:0]         rf_wdata,
  output logic                vrf_we,
  output logic [3:0]          vrf_waddr,
  output logic [LANE_W-1:0]   vrf_lane,
  output logic [15:0]         vrf_wdata,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         halt_pc,
  output logic [15:0]         retired_count
);
  import cpu_pkg::*;

  op_class_e    cls;
  logic         accept;
  logic         last_lane;
  vseq_state_e  seq_state;

  // Valid/ready: a transfer happens on a rising edge where in_valid && in_ready;
  // upstream holds its payload stable while in_valid is high and in_ready is low.
  assign in_ready = !halted && ((seq_state == ST_IDLE) || last_lane);
  assign accept   = in_valid && in_ready;
  assign cls      = op_class(in_opcode);

  vlane_sequencer #(
    .VLEN   (VLEN),
    .LANE_W (LANE_W)
  ) u_vseq (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (accept && (cls == CLS_VECTOR)),
    .start_rt    (in_rt),
    .start_vdata (in_vresult),
    .vrf_we      (vrf_we),
    .vrf_waddr   (vrf_waddr),
    .vrf_lane    (vrf_lane),
    .vrf_wdata   (vrf_wdata),
    .busy        (busy),
    .last_lane   (last_lane),
    .state_dbg   (seq_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      halted        <= 1'b0;
      halt_pc       <= '0;
      retired_count <= '0;
    end else begin
      rf_we <= accept && (cls == CLS_SCALAR);
      if (accept && (cls == CLS_SCALAR)) begin
        rf_waddr <= in_rt;
        rf_wdata <= in_result;
      end
      if (accept && (cls == CLS_HALT)) begin
        halted  <= 1'b1;
        halt_pc <= in_pc;
      end
      if (accept) retired_count <= retired_count + 16'd1;
    end
  end

endmodule
